seat_table_reader: RTL and testbench

- Read-side companion to the seat record memory, which is written by the seating controller.
- Sequentially reads every seat record through a synchronous read port.
- Produces occupancy counts and a mask of away-timeouts, and answers student-number lookups ("which seat is student X in").
- Feeds the status display and the controller's release logic.

---
 rtl/seat_table_reader.sv | 272 +++++++++++++++++++++++++++
 tb/tb_seat_table_reader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seat_table_reader.sv
// seat_table_reader: read-side scanner for the seat record memory.
// Walks every seat record through a synchronous read port. A status scan
// produces EMPTY / AWAY / OCCUPIED+RESERVED counts and a mask of AWAY seats
// whose timeout has expired. A lookup reports the lowest seat holding a
// given student number.
// Optional build macro SEAT_READER_AUTO_EN adds a free-running counter that
// requests a scan every AUTO_PERIOD cycles, in addition to start_scan.

module seat_table_reader #(
  parameter int SEATS       = 32,
  parameter int ADDR_W      = 5,
  parameter int SID_W       = 32,
  parameter int TIME_W      = 11,
  parameter int AUTO_PERIOD = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_scan,
  input  logic                find_req,
  input  logic [SID_W-1:0]    find_student,
  input  logic [TIME_W-1:0]   now_time,
  input  logic [TIME_W-1:0]   limit_time,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [SID_W-1:0]    rd_student,
  input  logic [TIME_W-1:0]   rd_time,
  input  logic [1:0]          rd_state,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     empty_cnt,
  output logic [ADDR_W:0]     away_cnt,
  output logic [ADDR_W:0]     occ_cnt,
  output logic [SEATS-1:0]    expired_mask,
  output logic                find_hit,
  output logic [ADDR_W-1:0]   find_seat
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SEATS - 1);

  // Record state encoding as stored by the seating controller.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_AWAY  = 2'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_FIND,
    S_DRAIN,
    S_DONE
  } state_t;

  // Elaboration-time sanity checks on the parameter set.
  if (SEATS > (1 << ADDR_W)) begin : g_bad_seats
    $error("SEATS does not fit in ADDR_W address bits");
  end
  if (AUTO_PERIOD < 2) begin : g_bad_period
    $error("AUTO_PERIOD must be at least 2");
  end

  state_t              state_q;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                mode_find_q;   // 1: current operation is a lookup
  logic                eval_valid_q;  // read data on rd_* belongs to eval_addr_q
  logic [ADDR_W-1:0]   eval_addr_q;

  // Shadow accumulators; published to the outputs only when a scan finishes.
  logic [CNT_W-1:0]    empty_sh_q, empty_sh_d;
  logic [CNT_W-1:0]    away_sh_q,  away_sh_d;
  logic [CNT_W-1:0]    occ_sh_q,   occ_sh_d;
  logic [SEATS-1:0]    mask_sh_q,  mask_sh_d;

  logic                busy_q;
  logic                done_q;
  logic [CNT_W-1:0]    empty_cnt_q, away_cnt_q, occ_cnt_q;
  logic [SEATS-1:0]    expired_mask_q;
  logic                find_hit_q;
  logic [ADDR_W-1:0]   find_seat_q;

  logic [TIME_W-1:0]   elapsed;
  logic                rec_expired;
  logic                rec_match;
  logic                eval_scan;
  logic                eval_find;
  logic                hit_now;
  logic                scan_req;

`ifdef SEAT_READER_AUTO_EN
  localparam int AUTO_W = $clog2(AUTO_PERIOD);

  logic [AUTO_W-1:0] auto_cnt_q;
  logic              auto_pend_q;
  logic              auto_tick;

  assign auto_tick = (auto_cnt_q == AUTO_W'(AUTO_PERIOD - 1));

  // Free-running period counter; a tick that lands mid-operation is held
  // (at most one) until the FSM is back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_cnt_q  <= '0;
      auto_pend_q <= 1'b0;
    end else begin
      auto_cnt_q <= auto_tick ? '0 : auto_cnt_q + AUTO_W'(1);
      if (state_q == S_IDLE) begin
        auto_pend_q <= 1'b0;
      end else if (auto_tick) begin
        auto_pend_q <= 1'b1;
      end
    end
  end

  assign scan_req = start_scan | auto_tick | auto_pend_q;
`else
  assign scan_req = start_scan;
`endif

  // Evaluate the record returned by the previous cycle's read.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    empty_sh_d = empty_sh_q;
    away_sh_d  = away_sh_q;
    occ_sh_d   = occ_sh_q;
    mask_sh_d  = mask_sh_q;

    // Modular subtraction handles the timestamp wrapping past 2^TIME_W.
    elapsed     = now_time - rd_time;
    rec_expired = (rd_state == ST_AWAY) && (elapsed > limit_time);
    rec_match   = (rd_student == find_student) && (rd_state != ST_EMPTY);

    eval_scan = eval_valid_q && !mode_find_q &&
                ((state_q == S_SCAN) || (state_q == S_DRAIN));
    eval_find = eval_valid_q && mode_find_q &&
                ((state_q == S_FIND) || (state_q == S_DRAIN));
    hit_now   = eval_find && rec_match;

    if (eval_scan) begin
      case (rd_state)
        ST_EMPTY: empty_sh_d = empty_sh_q + CNT_W'(1);
        ST_AWAY: begin
          away_sh_d = away_sh_q + CNT_W'(1);
          if (rec_expired) begin
            mask_sh_d[eval_addr_q] = 1'b1;
          end
        end
        default:  occ_sh_d = occ_sh_q + CNT_W'(1);
      endcase
    end
  end

  // Control FSM with registered read strobe, status and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rd_en_q        <= 1'b0;
      rd_addr_q      <= '0;
      mode_find_q    <= 1'b0;
      eval_valid_q   <= 1'b0;
      eval_addr_q    <= '0;
      empty_sh_q     <= '0;
      away_sh_q      <= '0;
      occ_sh_q       <= '0;
      mask_sh_q      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      empty_cnt_q    <= '0;
      away_cnt_q     <= '0;
      occ_cnt_q      <= '0;
      expired_mask_q <= '0;
      find_hit_q     <= 1'b0;
      find_seat_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments only, so every register sees pre-edge values.
      done_q       <= 1'b0;
      eval_valid_q <= rd_en_q;
      eval_addr_q  <= rd_addr_q;
      empty_sh_q   <= empty_sh_d;
      away_sh_q    <= away_sh_d;
      occ_sh_q     <= occ_sh_d;
      mask_sh_q    <= mask_sh_d;

      case (state_q)
        S_IDLE: begin
          if (scan_req) begin
            state_q     <= S_SCAN;
            mode_find_q <= 1'b0;
            rd_en_q     <= 1'b1;
            rd_addr_q   <= '0;
            busy_q      <= 1'b1;
            empty_sh_q  <= '0;
            away_sh_q   <= '0;
            occ_sh_q    <= '0;
            mask_sh_q   <= '0;
          end else if (find_req) begin
            state_q     <= S_FIND;
            mode_find_q <= 1'b1;
            rd_en_q     <= 1'b1;
            rd_addr_q   <= '0;
            busy_q      <= 1'b1;
          end
        end

        S_SCAN: begin
          if (rd_addr_q == LAST_ADDR) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            state_q   <= S_DRAIN;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
          end
        end

        S_FIND: begin
          if (hit_now) begin
            // First match is the lowest address; stop reading immediately.
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            find_hit_q  <= 1'b1;
            find_seat_q <= eval_addr_q;
          end else if (rd_addr_q == LAST_ADDR) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            state_q   <= S_DRAIN;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
          end
        end

        S_DRAIN: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
          if (mode_find_q) begin
            find_hit_q  <= hit_now;
            find_seat_q <= hit_now ? eval_addr_q : '0;
          end else begin
            // Publish all results together, including the last record.
            empty_cnt_q    <= empty_sh_d;
            away_cnt_q     <= away_sh_d;
            occ_cnt_q      <= occ_sh_d;
            expired_mask_q <= mask_sh_d;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          rd_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_en        = rd_en_q;
  assign rd_addr      = rd_addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign empty_cnt    = empty_cnt_q;
  assign away_cnt     = away_cnt_q;
  assign occ_cnt      = occ_cnt_q;
  assign expired_mask = expired_mask_q;
  assign find_hit     = find_hit_q;
  assign find_seat    = find_seat_q;

endmodule

// File: tb/tb_seat_table_reader.sv
// Scoreboard bench for seat_table_reader: the stimulus process pushes the
// hand-computed result and done cycle of each operation; a monitor pops and
// compares whenever done is seen.

module tb_seat_table_reader;

  localparam int SEATS  = 32;
  localparam int ADDR_W = 5;
  localparam int SID_W  = 32;
  localparam int TIME_W = 11;
  localparam logic [31:0] STUDENT_X = 32'h2023_1234;

  logic              clk;
  logic              rst;
  logic              start_scan;
  logic              find_req;
  logic [SID_W-1:0]  find_student;
  logic [TIME_W-1:0] now_time;
  logic [TIME_W-1:0] limit_time;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [SID_W-1:0]  rd_student;
  logic [TIME_W-1:0] rd_time;
  logic [1:0]        rd_state;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   empty_cnt;
  logic [ADDR_W:0]   away_cnt;
  logic [ADDR_W:0]   occ_cnt;
  logic [SEATS-1:0]  expired_mask;
  logic              find_hit;
  logic [ADDR_W-1:0] find_seat;

  seat_table_reader dut (
    .clk          (clk),
    .rst          (rst),
    .start_scan   (start_scan),
    .find_req     (find_req),
    .find_student (find_student),
    .now_time     (now_time),
    .limit_time   (limit_time),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_student   (rd_student),
    .rd_time      (rd_time),
    .rd_state     (rd_state),
    .busy         (busy),
    .done         (done),
    .empty_cnt    (empty_cnt),
    .away_cnt     (away_cnt),
    .occ_cnt      (occ_cnt),
    .expired_mask (expired_mask),
    .find_hit     (find_hit),
    .find_seat    (find_seat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Seat record memory model with a one-cycle synchronous read.
  logic [SID_W-1:0]  mem_sid   [SEATS];
  logic [TIME_W-1:0] mem_time  [SEATS];
  logic [1:0]        mem_state [SEATS];

  always @(posedge clk) begin
    if (rd_en) begin
      rd_student <= mem_sid[rd_addr];
      rd_time    <= mem_time[rd_addr];
      rd_state   <= mem_state[rd_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_find;
    int          e_cyc;
    logic [5:0]  e_empty;
    logic [5:0]  e_away;
    logic [5:0]  e_occ;
    logic [31:0] e_mask;
    logic        e_hit;
    logic [4:0]  e_seat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_scan(input int c, input int e, input int a, input int o,
                                   input logic [31:0] m);
    exp_t x;
    x.is_find = 1'b0;
    x.e_cyc   = c;
    x.e_empty = 6'(e);
    x.e_away  = 6'(a);
    x.e_occ   = 6'(o);
    x.e_mask  = m;
    x.e_hit   = 1'b0;
    x.e_seat  = '0;
    return x;
  endfunction

  function automatic exp_t mk_find(input int c, input logic h, input int s);
    exp_t x;
    x.is_find = 1'b1;
    x.e_cyc   = c;
    x.e_empty = '0;
    x.e_away  = '0;
    x.e_occ   = '0;
    x.e_mask  = '0;
    x.e_hit   = h;
    x.e_seat  = 5'(s);
    return x;
  endfunction

  // Monitor: pop the oldest expectation on every done pulse and compare.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: done at cycle %0d with nothing expected", cyc);
      end else begin
        e = sb.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.e_cyc));
        check("busy_in_done", 64'(busy), 64'd1);
        if (e.is_find) begin
          check("find_hit", 64'(find_hit), 64'(e.e_hit));
          check("find_seat", 64'(find_seat), 64'(e.e_seat));
        end else begin
          check("empty_cnt", 64'(empty_cnt), 64'(e.e_empty));
          check("away_cnt", 64'(away_cnt), 64'(e.e_away));
          check("occ_cnt", 64'(occ_cnt), 64'(e.e_occ));
          check("expired_mask", 64'(expired_mask), 64'(e.e_mask));
        end
      end
    end
  end

  // Wait (bounded) until the monitor has counted at least target done pulses.
  task automatic wait_done(input int target, input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt >= target) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: done_cnt=%0d required=%0d", name, done_cnt, target);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_scan(input exp_t e_in, input bit push);
    exp_t e;
    @(negedge clk);
    e = e_in;
    e.e_cyc = cyc + SEATS + 2;
    if (push) sb.push_back(e);
    start_scan = 1'b1;
    @(negedge clk);
    start_scan = 1'b0;
  endtask

  task automatic set_seat(input int a, input logic [1:0] st, input logic [31:0] sid,
                          input logic [10:0] t);
    mem_state[a] = st;
    mem_sid[a]   = sid;
    mem_time[a]  = t;
  endtask

  initial begin
    int tgt;
    int s;
    bit found;
    for (int i = 0; i < SEATS; i++) set_seat(i, 2'd0, 32'd0, 11'd0);
    rd_student   = '0;
    rd_time      = '0;
    rd_state     = '0;
    rst          = 1'b1;
    start_scan   = 1'b0;
    find_req     = 1'b0;
    find_student = '0;
    now_time     = '0;
    limit_time   = '0;
    idle_cycles(3);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_empty", 64'(empty_cnt), 64'd0);
    check("rst_mask", 64'(expired_mask), 64'd0);
    rst = 1'b0;
    idle_cycles(2);

    // 1: all seats EMPTY.
    tgt = done_cnt + 1;
    pulse_scan(mk_scan(0, 32, 0, 0, 32'h0), 1'b1);
    #1;
    check("busy_during_scan", 64'(busy), 64'd1);
    wait_done(tgt, 60, "scan_empty");

    // 2: expiry boundary, elapsed 100 (not expired) vs 101 (expired).
    set_seat(4, 2'd1, 32'd0, 11'd100);
    set_seat(5, 2'd1, 32'd0, 11'd99);
    now_time   = 11'd200;
    limit_time = 11'd100;
    tgt = done_cnt + 1;
    pulse_scan(mk_scan(0, 30, 2, 0, 32'h0000_0020), 1'b1);
    wait_done(tgt, 60, "scan_boundary");

    // 3: timer wrap on seat 7 (elapsed 18 > 5), plus occupied/reserved seats.
    set_seat(4, 2'd0, 32'd0, 11'd0);
    set_seat(5, 2'd0, 32'd0, 11'd0);
    set_seat(7, 2'd1, 32'd0, 11'd2040);
    set_seat(3, 2'd3, STUDENT_X, 11'd0);
    set_seat(9, 2'd3, STUDENT_X, 11'd0);
    set_seat(10, 2'd2, 32'h0000_1111, 11'd0);
    now_time   = 11'd10;
    limit_time = 11'd5;
    tgt = done_cnt + 1;
    pulse_scan(mk_scan(0, 28, 1, 3, 32'h0000_0080), 1'b1);
    wait_done(tgt, 60, "scan_wrap");

    // 4: lookup hit at lowest seat 3, done 6 cycles after request.
    @(negedge clk);
    find_student = STUDENT_X;
    sb.push_back(mk_find(cyc + 6, 1'b1, 3));
    find_req = 1'b1;
    tgt = done_cnt + 1;
    wait_done(tgt, 20, "find_hit");
    find_req = 1'b0;
    check("counts_kept_after_find", 64'(empty_cnt), 64'd28);

    // 5: only EMPTY record carries the student -> miss after full sweep.
    set_seat(3, 2'd0, STUDENT_X, 11'd0);
    set_seat(9, 2'd3, 32'h0BAD_F00D, 11'd0);
    @(negedge clk);
    sb.push_back(mk_find(cyc + SEATS + 2, 1'b0, 0));
    find_req = 1'b1;
    tgt = done_cnt + 1;
    wait_done(tgt, 60, "find_miss");
    find_req = 1'b0;

    // 6: start_scan and find_req together: scan first, then held lookup.
    set_seat(3, 2'd3, STUDENT_X, 11'd0);
    @(negedge clk);
    s = cyc;
    sb.push_back(mk_scan(s + SEATS + 2, 28, 1, 3, 32'h0000_0080));
    sb.push_back(mk_find(s + SEATS + 9, 1'b1, 3));
    start_scan = 1'b1;
    find_req   = 1'b1;
    @(negedge clk);
    start_scan = 1'b0;
    tgt = done_cnt + 2;
    wait_done(tgt, 100, "scan_then_find");
    find_req = 1'b0;

    // 7: start_scan mid-scan is ignored; exactly one done.
    tgt = done_cnt + 1;
    pulse_scan(mk_scan(0, 28, 1, 3, 32'h0000_0080), 1'b1);
    idle_cycles(9);
    start_scan = 1'b1;
    @(negedge clk);
    start_scan = 1'b0;
    wait_done(tgt, 60, "scan_ignore");
    idle_cycles(40);
    #1;
    check("single_done", 64'(done_cnt), 64'(tgt));

    // 8: asynchronous reset at scan address 15 aborts without done.
    tgt = done_cnt;
    pulse_scan(mk_scan(0, 0, 0, 0, 32'h0), 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (rd_addr == 5'd15 && rd_en) found = 1'b1;
      else @(negedge clk);
    end
    check("reached_addr15", 64'(found), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_rd_en", 64'(rd_en), 64'd0);
    check("abort_empty", 64'(empty_cnt), 64'd0);
    check("abort_occ", 64'(occ_cnt), 64'd0);
    check("abort_mask", 64'(expired_mask), 64'd0);
    check("abort_find_hit", 64'(find_hit), 64'd0);
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(40);
    #1;
    check("abort_no_done", 64'(done_cnt), 64'(tgt));

    // 9: scan after the abort completes normally.
    tgt = done_cnt + 1;
    pulse_scan(mk_scan(0, 28, 1, 3, 32'h0000_0080), 1'b1);
    wait_done(tgt, 60, "scan_after_reset");

    idle_cycles(2);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
